sc_fibonacci_seq: RTL and testbench

Sequence generator that consumes the two constant seed buses produced by the fixed-value registers (F0, F1) and emits successive Fibonacci terms, one per clock, up to a programmable term count. It sits directly downstream of the seed registers and feeds the display/compare stages of the Fibonacci datapath. Each run stops when the requested number of terms has been emitted, or when the next term no longer fits in `DATAWIDTH_BUS` bits.

---
 rtl/sc_fibonacci_seq_if.sv | 33 +++
 rtl/sc_fibonacci_seq.sv | 126 ++++++++++++
 tb/tb_sc_fibonacci_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sc_fibonacci_seq_if.sv
// Bundle of control, seed and result signals between the seed registers,
// the Fibonacci sequence generator and its downstream display/compare stages.
interface sc_fibonacci_seq_if #(
  parameter int unsigned DATAWIDTH_BUS  = 8,
  parameter int unsigned INDEXWIDTH_BUS = 8
);
  logic                      SC_FibSeq_start_In;
  logic [DATAWIDTH_BUS-1:0]  SC_FibSeq_seedA_InBUS;
  logic [DATAWIDTH_BUS-1:0]  SC_FibSeq_seedB_InBUS;
  logic [INDEXWIDTH_BUS-1:0] SC_FibSeq_limit_InBUS;
  logic [DATAWIDTH_BUS-1:0]  SC_FibSeq_data_OutBUS;
  logic [INDEXWIDTH_BUS-1:0] SC_FibSeq_index_OutBUS;
  logic                      SC_FibSeq_valid_Out;
  logic                      SC_FibSeq_busy_Out;
  logic                      SC_FibSeq_done_Out;
  logic                      SC_FibSeq_overflow_Out;

  // Requester side: drives start, seeds and limit, observes the sequence.
  modport master (
    output SC_FibSeq_start_In, SC_FibSeq_seedA_InBUS, SC_FibSeq_seedB_InBUS,
           SC_FibSeq_limit_InBUS,
    input  SC_FibSeq_data_OutBUS, SC_FibSeq_index_OutBUS, SC_FibSeq_valid_Out,
           SC_FibSeq_busy_Out, SC_FibSeq_done_Out, SC_FibSeq_overflow_Out
  );

  // Generator side.
  modport slave (
    input  SC_FibSeq_start_In, SC_FibSeq_seedA_InBUS, SC_FibSeq_seedB_InBUS,
           SC_FibSeq_limit_InBUS,
    output SC_FibSeq_data_OutBUS, SC_FibSeq_index_OutBUS, SC_FibSeq_valid_Out,
           SC_FibSeq_busy_Out, SC_FibSeq_done_Out, SC_FibSeq_overflow_Out
  );
endinterface

// File: rtl/sc_fibonacci_seq.sv
// Fibonacci sequence generator: loads two seeds, emits one term per clock up
// to a latched term count, and stops early when the next term would wrap.
module sc_fibonacci_seq #(
  parameter int unsigned DATAWIDTH_BUS  = 8,
  parameter int unsigned INDEXWIDTH_BUS = 8
) (
  input logic               SC_FibSeq_CLOCK_50,
  input logic               SC_FibSeq_RESET_InHigh,
  sc_fibonacci_seq_if.slave fibIf
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} stateT;

  stateT                     stateQ, stateD;
  logic [DATAWIDTH_BUS-1:0]  aQ, aD, bQ, bD;
  // Tags mark a value that has wrapped; a wrapped A is never emitted.
  logic                      taQ, taD, tbQ, tbD;
  logic [INDEXWIDTH_BUS-1:0] idxQ, idxD, limQ, limD, limM1;
  logic [DATAWIDTH_BUS-1:0]  dataQ, dataD;
  logic [INDEXWIDTH_BUS-1:0] indexQ, indexD;
  logic                      validQ, validD, doneQ, doneD, ovfQ, ovfD;
  logic [DATAWIDTH_BUS:0]    sum;

  assign limM1 = limQ - INDEXWIDTH_BUS'(1);

  // Next-state, datapath and registered-output next values.
  always_comb begin
    stateD = stateQ;
    aD     = aQ;
    bD     = bQ;
    taD    = taQ;
    tbD    = tbQ;
    idxD   = idxQ;
    limD   = limQ;
    dataD  = dataQ;
    indexD = indexQ;
    validD = 1'b0;
    doneD  = doneQ;
    ovfD   = ovfQ;
    sum    = {1'b0, aQ} + {1'b0, bQ};
    unique case (stateQ)
      StIdle: begin
        if (fibIf.SC_FibSeq_start_In) stateD = StLoad;
      end
      StLoad: begin
        aD   = fibIf.SC_FibSeq_seedA_InBUS;
        bD   = fibIf.SC_FibSeq_seedB_InBUS;
        taD  = 1'b0;
        tbD  = 1'b0;
        idxD = '0;
        limD = fibIf.SC_FibSeq_limit_InBUS;
        ovfD = 1'b0;
        if (fibIf.SC_FibSeq_limit_InBUS == '0) begin
          stateD = StDone;
          doneD  = 1'b1;
        end else begin
          stateD = StRun;
          doneD  = 1'b0;
        end
      end
      StRun: begin
        if (taQ) begin
          stateD = StDone;
          doneD  = 1'b1;
          ovfD   = 1'b1;
        end else begin
          dataD  = aQ;
          indexD = idxQ;
          validD = 1'b1;
          aD     = bQ;
          taD    = tbQ;
          bD     = sum[DATAWIDTH_BUS-1:0];
          tbD    = sum[DATAWIDTH_BUS] | taQ | tbQ;
          idxD   = idxQ + INDEXWIDTH_BUS'(1);
          if (idxQ == limM1) begin
            stateD = StDone;
            doneD  = 1'b1;
          end
        end
      end
      StDone: begin
        if (fibIf.SC_FibSeq_start_In) stateD = StLoad;
      end
      default: stateD = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge SC_FibSeq_CLOCK_50) begin
    if (SC_FibSeq_RESET_InHigh) begin
      stateQ <= StIdle;
      aQ     <= '0;
      bQ     <= '0;
      taQ    <= 1'b0;
      tbQ    <= 1'b0;
      idxQ   <= '0;
      limQ   <= '0;
      dataQ  <= '0;
      indexQ <= '0;
      validQ <= 1'b0;
      doneQ  <= 1'b0;
      ovfQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      aQ     <= aD;
      bQ     <= bD;
      taQ    <= taD;
      tbQ    <= tbD;
      idxQ   <= idxD;
      limQ   <= limD;
      dataQ  <= dataD;
      indexQ <= indexD;
      validQ <= validD;
      doneQ  <= doneD;
      ovfQ   <= ovfD;
    end
  end

  assign fibIf.SC_FibSeq_data_OutBUS  = dataQ;
  assign fibIf.SC_FibSeq_index_OutBUS = indexQ;
  assign fibIf.SC_FibSeq_valid_Out    = validQ;
  assign fibIf.SC_FibSeq_done_Out     = doneQ;
  assign fibIf.SC_FibSeq_overflow_Out = ovfQ;
  assign fibIf.SC_FibSeq_busy_Out     = (stateQ == StLoad) || (stateQ == StRun);

endmodule

// File: tb/tb_sc_fibonacci_seq.sv
// Directed bench for sc_fibonacci_seq with hand-computed expected terms.
module tb_sc_fibonacci_seq;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  int unsigned fibTab [14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  sc_fibonacci_seq_if #(.DATAWIDTH_BUS(8), .INDEXWIDTH_BUS(8)) fibIf ();

  sc_fibonacci_seq #(.DATAWIDTH_BUS(8), .INDEXWIDTH_BUS(8)) dut (
    .SC_FibSeq_CLOCK_50    (clock),
    .SC_FibSeq_RESET_InHigh(reset),
    .fibIf                 (fibIf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOut(input string tag, input int unsigned data, input int unsigned index,
                          input int unsigned valid, input int unsigned busy,
                          input int unsigned done, input int unsigned ovf);
    check({tag, ".data"}, 32'(fibIf.SC_FibSeq_data_OutBUS), data);
    check({tag, ".index"}, 32'(fibIf.SC_FibSeq_index_OutBUS), index);
    check({tag, ".valid"}, 32'(fibIf.SC_FibSeq_valid_Out), valid);
    check({tag, ".busy"}, 32'(fibIf.SC_FibSeq_busy_Out), busy);
    check({tag, ".done"}, 32'(fibIf.SC_FibSeq_done_Out), done);
    check({tag, ".overflow"}, 32'(fibIf.SC_FibSeq_overflow_Out), ovf);
  endtask

  task automatic setIn(input logic start, input int unsigned sa, input int unsigned sb,
                       input int unsigned lim);
    fibIf.SC_FibSeq_start_In    = start;
    fibIf.SC_FibSeq_seedA_InBUS = 8'(sa);
    fibIf.SC_FibSeq_seedB_InBUS = 8'(sb);
    fibIf.SC_FibSeq_limit_InBUS = 8'(lim);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    setIn(1'b0, 0, 1, 10);
    tick();
    tick();
    checkOut("reset", 0, 0, 0, 0, 0, 0);

    // Seeds 0,1, limit 10.
    reset = 1'b0;
    setIn(1'b1, 0, 1, 10);
    tick();
    checkOut("t1.load", 0, 0, 0, 1, 0, 0);
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    checkOut("t1.run0", 0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 10; n++) begin
      tick();
      checkOut("t1.term", fibTab[n], n, 1, (n != 9) ? 1 : 0, (n == 9) ? 1 : 0, 0);
    end
    tick();
    checkOut("t1.done", 34, 9, 0, 0, 1, 0);

    // Limit 20 stops on overflow after 233.
    setIn(1'b1, 0, 1, 20);
    tick();
    checkOut("t2.load", 34, 9, 0, 1, 1, 0);
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    checkOut("t2.run0", 34, 9, 0, 1, 0, 0);
    for (int n = 0; n < 14; n++) begin
      tick();
      checkOut("t2.term", fibTab[n], n, 1, 1, 0, 0);
    end
    tick();
    checkOut("t2.ovf", 233, 13, 0, 0, 1, 1);
    tick();
    checkOut("t2.hold", 233, 13, 0, 0, 1, 1);

    // Limit 0 then limit 1, seeds 5,7.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setIn(1'b1, 5, 7, 0);
    tick();
    checkOut("t3.load0", 0, 0, 0, 1, 0, 0);
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    checkOut("t3.lim0", 0, 0, 0, 0, 1, 0);
    tick();
    checkOut("t3.lim0b", 0, 0, 0, 0, 1, 0);
    setIn(1'b1, 5, 7, 1);
    tick();
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    checkOut("t3.run1", 0, 0, 0, 1, 0, 0);
    tick();
    checkOut("t3.lim1", 5, 0, 1, 0, 1, 0);
    tick();
    checkOut("t3.lim1b", 5, 0, 0, 0, 1, 0);

    // Start held high, seeds 2,3, limit 4.
    setIn(1'b1, 2, 3, 4);
    tick();
    tick();
    for (int n = 0; n < 4; n++) begin
      tick();
      check("t4.data", 32'(fibIf.SC_FibSeq_data_OutBUS), 32'(n < 2 ? n + 2 : (n == 2 ? 5 : 8)));
      check("t4.valid", 32'(fibIf.SC_FibSeq_valid_Out), 1);
    end
    check("t4.done", 32'(fibIf.SC_FibSeq_done_Out), 1);
    tick();
    checkOut("t4.reload", 8, 3, 0, 1, 1, 0);
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    for (int n = 0; n < 4; n++) tick();
    checkOut("t4.last", 8, 3, 1, 0, 1, 0);
    tick();
    tick();
    checkOut("t4.stay", 8, 3, 0, 0, 1, 0);

    // Reset on the cycle term 3 appears.
    setIn(1'b1, 0, 1, 10);
    tick();
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    for (int n = 0; n < 4; n++) tick();
    checkOut("t5.term3", 2, 3, 1, 1, 0, 0);
    reset = 1'b1;
    fibIf.SC_FibSeq_start_In = 1'b1;
    tick();
    checkOut("t5.reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    tick();
    checkOut("t5.replay0", 0, 0, 1, 1, 0, 0);
    tick();
    checkOut("t5.replay1", 1, 1, 1, 1, 0, 0);

    // Seeds/limit change mid-run has no effect; restart picks them up.
    setIn(1'b0, 5, 7, 3);
    for (int n = 2; n < 10; n++) begin
      tick();
      checkOut("t6.term", fibTab[n], n, 1, (n != 9) ? 1 : 0, (n == 9) ? 1 : 0, 0);
    end
    fibIf.SC_FibSeq_start_In = 1'b1;
    tick();
    fibIf.SC_FibSeq_start_In = 1'b0;
    tick();
    tick();
    checkOut("t6.new0", 5, 0, 1, 1, 0, 0);
    tick();
    checkOut("t6.new1", 7, 1, 1, 1, 0, 0);
    tick();
    checkOut("t6.new2", 12, 2, 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
